// File: rtl/nibble_parity_checker_if.sv
// Bus between a serial nibble source and the parity checker: bit-stream
// controls in, frame result and error count out.
interface nibble_parity_checker_if #(
    parameter int ERR_CNT_W = 8
);
    logic                 i_valid;
    logic                 i_bit;
    logic                 i_sync;
    logic                 i_clear;
    logic [3:0]           o_nibble;
    logic                 o_parity_ok;
    logic                 o_done;
    logic [ERR_CNT_W-1:0] o_err_cnt;
    logic                 o_busy;

    modport master (
        output i_valid, i_bit, i_sync, i_clear,
        input  o_nibble, o_parity_ok, o_done, o_err_cnt, o_busy
    );

    modport slave (
        input  i_valid, i_bit, i_sync, i_clear,
        output o_nibble, o_parity_ok, o_done, o_err_cnt, o_busy
    );
endinterface

// File: rtl/nibble_parity_checker.sv
// Collects 4 data bits plus a parity bit from a serial stream, rechecks the
// XOR4 parity and reports each nibble with a pass flag and an error count.
module nibble_parity_checker #(
    parameter bit ODD_PARITY = 1'b0,
    parameter int ERR_CNT_W  = 8
) (
    input logic                    i_clk,
    input logic                    i_rst_n,
    nibble_parity_checker_if.slave bus
);
    typedef enum logic {S_DATA, S_PAR} state_t;

    localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

    state_t               state, state_nxt;
    logic [2:0]           bit_cnt, bit_cnt_nxt;
    logic [3:0]           shift_q, shift_nxt;

    logic                 frame_end;
    logic                 frame_ok;
    logic                 busy_nxt;
    logic [ERR_CNT_W-1:0] err_nxt;

    logic [3:0]           nibble_q;
    logic                 ok_q;
    logic                 done_q;
    logic [ERR_CNT_W-1:0] err_q;
    logic                 busy_q;

    // NOTE: every register is reset, including the shift register, so a frame
    // aborted by reset leaves nothing behind that could leak into the next one.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state   <= S_DATA;
            bit_cnt <= 3'd0;
            shift_q <= 4'd0;
        end else begin
            // NOTE: non-blocking assignments so all registers update from the
            // same pre-edge values regardless of statement order.
            state   <= state_nxt;
            bit_cnt <= bit_cnt_nxt;
            shift_q <= shift_nxt;
        end
    end

    // NOTE: defaults first so every path assigns every signal and no latch
    // is inferred.
    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        shift_nxt   = shift_q;
        if (bus.i_sync) begin
            state_nxt   = S_DATA;
            bit_cnt_nxt = 3'd0;
            shift_nxt   = 4'd0;
        end else if (bus.i_valid) begin
            case (state)
                S_DATA: begin
                    shift_nxt   = {shift_q[2:0], bus.i_bit};
                    bit_cnt_nxt = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd3) begin
                        state_nxt = S_PAR;
                    end
                end
                S_PAR: begin
                    state_nxt   = S_DATA;
                    bit_cnt_nxt = 3'd0;
                end
                default: state_nxt = S_DATA;
            endcase
        end
    end

    // Sync on the parity cycle kills the frame: no result, no count.
    always_comb begin
        frame_end = (state == S_PAR) && bus.i_valid && !bus.i_sync;
        frame_ok  = (bus.i_bit == ((^shift_q) ^ ODD_PARITY));
        busy_nxt  = (bit_cnt_nxt != 3'd0) || (state_nxt == S_PAR);
        err_nxt   = err_q;
        if (bus.i_clear) begin
            err_nxt = '0;
        end else if (frame_end && !frame_ok && (err_q != ERR_MAX)) begin
            err_nxt = err_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            nibble_q <= 4'd0;
            ok_q     <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            done_q <= frame_end;
            if (frame_end) begin
                nibble_q <= shift_q;
                ok_q     <= frame_ok;
            end
            err_q  <= err_nxt;
            busy_q <= busy_nxt;
        end
    end

    assign bus.o_nibble    = nibble_q;
    assign bus.o_parity_ok = ok_q;
    assign bus.o_done      = done_q;
    assign bus.o_err_cnt   = err_q;
    assign bus.o_busy      = busy_q;
endmodule

// File: tb/tb_nibble_parity_checker.sv
// Drives one shared bit stream into three checker configurations (even/8-bit,
// odd/8-bit, even/2-bit counter) and compares each against a frame-level model.
module tb_nibble_parity_checker;
    logic clk;
    logic rst_n;
    logic valid;
    logic bit_in;
    logic sync;
    logic clear;

    nibble_parity_checker_if #(.ERR_CNT_W(8)) if0 ();
    nibble_parity_checker_if #(.ERR_CNT_W(8)) if1 ();
    nibble_parity_checker_if #(.ERR_CNT_W(2)) if2 ();

    assign if0.i_valid = valid;  assign if0.i_bit = bit_in;
    assign if0.i_sync  = sync;   assign if0.i_clear = clear;
    assign if1.i_valid = valid;  assign if1.i_bit = bit_in;
    assign if1.i_sync  = sync;   assign if1.i_clear = clear;
    assign if2.i_valid = valid;  assign if2.i_bit = bit_in;
    assign if2.i_sync  = sync;   assign if2.i_clear = clear;

    nibble_parity_checker #(.ODD_PARITY(1'b0), .ERR_CNT_W(8)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .bus(if0.slave));
    nibble_parity_checker #(.ODD_PARITY(1'b1), .ERR_CNT_W(8)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .bus(if1.slave));
    nibble_parity_checker #(.ODD_PARITY(1'b0), .ERR_CNT_W(2)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .bus(if2.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;
    int done_seen    = 0;

    // Frame-level reference: a queue of accepted bits, resolved every 5th bit.
    bit         model_on = 1'b0;
    bit         mq[$];
    logic [3:0] m_nib;
    logic       m_done;
    logic       m_busy;
    logic       m_ok[3];
    int         m_cnt[3];
    int         cnt_max[3] = '{255, 255, 3};
    bit         odd[3]     = '{1'b0, 1'b1, 1'b0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit frame_done;
        bit par;
        int ones;
        if (!rst_n) begin
            mq.delete();
            m_nib = 4'd0; m_done = 1'b0; m_busy = 1'b0;
            for (int c = 0; c < 3; c++) begin
                m_ok[c] = 1'b0; m_cnt[c] = 0;
            end
            model_on = 1'b1;
            return;
        end
        frame_done = 1'b0;
        par        = 1'b0;
        ones       = 0;
        m_done     = 1'b0;
        if (sync) begin
            mq.delete();
        end else if (valid) begin
            mq.push_back(bit_in);
            if (mq.size() == 5) begin
                m_nib = {mq[0], mq[1], mq[2], mq[3]};
                for (int i = 0; i < 4; i++) ones += int'(mq[i]);
                par        = mq[4];
                frame_done = 1'b1;
                m_done     = 1'b1;
                mq.delete();
            end
        end
        for (int c = 0; c < 3; c++) begin
            if (frame_done) begin
                m_ok[c] = (par == ((ones % 2 == 1) ^ odd[c]));
                if (!m_ok[c] && m_cnt[c] < cnt_max[c]) m_cnt[c]++;
            end
            if (clear) m_cnt[c] = 0;
        end
        m_busy = (mq.size() != 0);
    endtask

    task automatic compare_dut(input int c, input logic done, input logic busy,
                               input logic ok, input logic [3:0] nib, input logic [31:0] cnt);
        check($sformatf("d%0d done", c), 32'(done), 32'(m_done));
        check($sformatf("d%0d busy", c), 32'(busy), 32'(m_busy));
        check($sformatf("d%0d ok", c),   32'(ok),   32'(m_ok[c]));
        check($sformatf("d%0d nib", c),  32'(nib),  32'(m_nib));
        check($sformatf("d%0d cnt", c),  cnt,       32'(m_cnt[c]));
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        if (if0.o_done === 1'b1) done_seen++;
        if (model_on) begin
            compare_dut(0, if0.o_done, if0.o_busy, if0.o_parity_ok, if0.o_nibble, 32'(if0.o_err_cnt));
            compare_dut(1, if1.o_done, if1.o_busy, if1.o_parity_ok, if1.o_nibble, 32'(if1.o_err_cnt));
            compare_dut(2, if2.o_done, if2.o_busy, if2.o_parity_ok, if2.o_nibble, 32'(if2.o_err_cnt));
        end
    endtask

    task automatic send_bit(input logic b, input int gap_max);
        int gap;
        gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
        for (int g = 0; g < gap; g++) begin
            valid = 1'b0;
            step();
        end
        valid  = 1'b1;
        bit_in = b;
        step();
        valid = 1'b0;
    endtask

    // Frame is a,b,c,d,parity from bit 4 down to bit 0.
    task automatic send_frame(input logic [4:0] f, input bit clr_on_par, input int gap_max);
        for (int i = 4; i >= 0; i--) begin
            clear = clr_on_par && (i == 0);
            send_bit(f[i], gap_max);
            clear = 1'b0;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " d0 outs"}, {25'd0, if0.o_done, if0.o_busy, if0.o_parity_ok, if0.o_nibble}, 32'd0);
        check({tag, " d1 outs"}, {25'd0, if1.o_done, if1.o_busy, if1.o_parity_ok, if1.o_nibble}, 32'd0);
        check({tag, " d2 outs"}, {25'd0, if2.o_done, if2.o_busy, if2.o_parity_ok, if2.o_nibble}, 32'd0);
        check({tag, " cnts"}, {8'd0, if0.o_err_cnt, if1.o_err_cnt, 6'd0, if2.o_err_cnt}, 32'd0);
    endtask

    typedef struct {
        logic [4:0] frame;
        bit         clr;
        logic [3:0] nib;
        bit         ok_even;
        bit         ok_odd;
        int         cnt0;
        int         cnt1;
        int         cnt2;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int base;
        vecs[0] = '{5'b10111, 1'b0, 4'b1011, 1'b1, 1'b0, 0, 1, 0};
        vecs[1] = '{5'b10110, 1'b0, 4'b1011, 1'b0, 1'b1, 1, 1, 1};
        vecs[2] = '{5'b00001, 1'b0, 4'b0000, 1'b0, 1'b1, 2, 1, 2};
        vecs[3] = '{5'b00001, 1'b0, 4'b0000, 1'b0, 1'b1, 3, 1, 3};
        vecs[4] = '{5'b00001, 1'b0, 4'b0000, 1'b0, 1'b1, 4, 1, 3};
        vecs[5] = '{5'b00001, 1'b0, 4'b0000, 1'b0, 1'b1, 5, 1, 3};
        vecs[6] = '{5'b00001, 1'b1, 4'b0000, 1'b0, 1'b1, 0, 0, 0};

        rst_n = 1'b0; valid = 1'b0; bit_in = 1'b0; sync = 1'b0; clear = 1'b0;
        step();
        check_all_zero("reset");
        step();
        rst_n = 1'b1;

        for (int v = 0; v < 7; v++) begin
            send_frame(vecs[v].frame, vecs[v].clr, 0);
            check($sformatf("vec%0d done", v), 32'(if0.o_done), 32'd1);
            check($sformatf("vec%0d nib", v), 32'(if0.o_nibble), 32'(vecs[v].nib));
            check($sformatf("vec%0d ok even", v), 32'(if0.o_parity_ok), 32'(vecs[v].ok_even));
            check($sformatf("vec%0d ok odd", v), 32'(if1.o_parity_ok), 32'(vecs[v].ok_odd));
            check($sformatf("vec%0d cnt0", v), 32'(if0.o_err_cnt), 32'(vecs[v].cnt0));
            check($sformatf("vec%0d cnt1", v), 32'(if1.o_err_cnt), 32'(vecs[v].cnt1));
            check($sformatf("vec%0d cnt2", v), 32'(if2.o_err_cnt), 32'(vecs[v].cnt2));
            step();
            check($sformatf("vec%0d done drop", v), 32'(if0.o_done), 32'd0);
        end

        base = done_seen;
        for (int n = 0; n < 16; n++) begin
            logic [3:0] nv;
            nv = 4'(n);
            send_frame({nv, ^nv}, 1'b0, 3);
            check($sformatf("sweep%0d nib", n), 32'(if0.o_nibble), 32'(nv));
            check($sformatf("sweep%0d ok", n), 32'(if0.o_parity_ok), 32'd1);
        end
        step();
        check("sweep done pulses", 32'(done_seen - base), 32'd16);
        check("sweep cnt0", 32'(if0.o_err_cnt), 32'd0);

        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        sync = 1'b1;
        step();
        sync = 1'b0;
        check("sync busy", 32'(if0.o_busy), 32'd0);
        base = done_seen;
        send_frame(5'b00011, 1'b0, 0);
        step();
        check("sync one done", 32'(done_seen - base), 32'd1);
        check("sync nib", 32'(if0.o_nibble), 32'd1);
        check("sync ok", 32'(if0.o_parity_ok), 32'd1);

        for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
        valid = 1'b1; bit_in = 1'b1; sync = 1'b1;
        step();
        valid = 1'b0; sync = 1'b0;
        check("sync on parity done", 32'(if0.o_done), 32'd0);
        check("sync on parity busy", 32'(if0.o_busy), 32'd0);
        check("sync on parity nib", 32'(if0.o_nibble), 32'd1);

        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_all_zero("mid reset");
        base = done_seen;
        send_frame(5'b01100, 1'b0, 0);
        check("post reset nib", 32'(if0.o_nibble), 32'b0110);
        check("post reset ok", 32'(if0.o_parity_ok), 32'd1);
        step();
        check("post reset one done", 32'(done_seen - base), 32'd1);

        for (int i = 0; i < 3000; i++) begin
            valid  = ($urandom_range(0, 3) != 0);
            bit_in = 1'($urandom_range(0, 1));
            sync   = ($urandom_range(0, 39) == 0);
            clear  = ($urandom_range(0, 149) == 0);
            rst_n  = ($urandom_range(0, 499) != 0);
            step();
        end
        rst_n = 1'b1; valid = 1'b0; sync = 1'b0; clear = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, expected completion before 2ms");
        $fatal(1, "watchdog expired");
    end
endmodule
